// File: rtl/frame_deserializer.sv
// Receive side of the frame link: rebuilds the parallel frame from a 1-bit serial stream,
// checks even parity and presents a double-buffered frame plus laser/alien decodes.
module frame_deserializer #(
    parameter int unsigned OBJ_LIMIT = 8,
    parameter int unsigned ALIEN_W   = 18,
    parameter int unsigned LASER_W   = 14,
    parameter int unsigned FRAME_W   = OBJ_LIMIT * ALIEN_W + LASER_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ser_valid,
    input  logic                 ser_data,
    input  logic                 ser_sof,
    output logic [FRAME_W-1:0]   frame_out,
    output logic                 frame_valid,
    output logic                 parity_err,
    output logic                 sync_err,
    output logic                 busy,
    output logic [7:0]           frame_cnt,
    output logic                 laser_active,
    output logic [3:0]           laser_r,
    output logic [8:0]           laser_deg,
    output logic [OBJ_LIMIT-1:0] alien_present
);

    localparam int unsigned     CntW    = $clog2(FRAME_W + 1);
    localparam int unsigned     IdxW    = $clog2(FRAME_W);
    localparam logic [CntW-1:0] CntLast = CntW'(FRAME_W);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {StIdle, StRecv, StCommit} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               par_q, par_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               frame_valid_q, frame_valid_d;
    logic               parity_err_q, parity_err_d;
    logic               sync_err_q, sync_err_d;

    logic               start_beat;
    logic               data_beat;
    logic [FRAME_W-1:0] first_bit;

    assign start_beat = ser_valid & ser_sof;
    assign data_beat  = ser_valid & ~ser_sof;
    assign first_bit  = FRAME_W'(ser_data);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        frame_d       = frame_q;
        frame_cnt_d   = frame_cnt_q;
        frame_valid_d = 1'b0;
        parity_err_d  = 1'b0;
        sync_err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_beat) begin
                    state_d = StRecv;
                    cnt_d   = CntOne;
                    shift_d = first_bit;
                    par_d   = ser_data;
                end
            end
            StRecv: begin
                if (start_beat) begin
                    // Early sof: drop the partial frame and restart on this beat.
                    sync_err_d = 1'b1;
                    cnt_d      = CntOne;
                    shift_d    = first_bit;
                    par_d      = ser_data;
                end else if (data_beat) begin
                    par_d = par_q ^ ser_data;
                    if (cnt_q == CntLast) begin
                        state_d = StCommit;
                    end else begin
                        shift_d[cnt_q[IdxW-1:0]] = ser_data;
                        cnt_d                    = cnt_q + CntOne;
                    end
                end
            end
            StCommit: begin
                if (!par_q) begin
                    frame_d       = shift_q;
                    frame_valid_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 8'd1;
                end else begin
                    parity_err_d = 1'b1;
                end
                state_d = StIdle;
                cnt_d   = '0;
                // A sof here starts the next frame with no idle gap.
                if (start_beat) begin
                    state_d = StRecv;
                    cnt_d   = CntOne;
                    shift_d = first_bit;
                    par_d   = ser_data;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            frame_q       <= '0;
            frame_cnt_q   <= '0;
            frame_valid_q <= 1'b0;
            parity_err_q  <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            frame_q       <= frame_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_valid_q <= frame_valid_d;
            parity_err_q  <= parity_err_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign frame_out    = frame_q;
    assign frame_valid  = frame_valid_q;
    assign parity_err   = parity_err_q;
    assign sync_err     = sync_err_q;
    assign frame_cnt    = frame_cnt_q;
    assign busy         = (state_q == StRecv);

    assign laser_active = frame_q[0];
    assign laser_r      = frame_q[4:1];
    assign laser_deg    = frame_q[13:5];

    for (genvar k = 0; k < OBJ_LIMIT; k++) begin : g_present
        assign alien_present[k] = frame_q[LASER_W + k * ALIEN_W];
    end

endmodule

// File: tb/tb_frame_deserializer.sv
// Self-checking bench for frame_deserializer (OBJ_LIMIT=2): table-driven frames, hand-written
// corner sequences and random streams, all checked every cycle against a queue-based model.
module tb_frame_deserializer;

    localparam int unsigned OBJ = 2;
    localparam int unsigned AW  = 18;
    localparam int unsigned LW  = 14;
    localparam int unsigned FW  = OBJ * AW + LW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ser_valid = 1'b0;
    logic          ser_data = 1'b0;
    logic          ser_sof = 1'b0;
    logic [FW-1:0] frame_out;
    logic          frame_valid, parity_err, sync_err, busy;
    logic [7:0]    frame_cnt;
    logic          laser_active;
    logic [3:0]    laser_r;
    logic [8:0]    laser_deg;
    logic [OBJ-1:0] alien_present;

    frame_deserializer #(
        .OBJ_LIMIT (OBJ),
        .ALIEN_W   (AW),
        .LASER_W   (LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ser_valid     (ser_valid),
        .ser_data      (ser_data),
        .ser_sof       (ser_sof),
        .frame_out     (frame_out),
        .frame_valid   (frame_valid),
        .parity_err    (parity_err),
        .sync_err      (sync_err),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .laser_active  (laser_active),
        .laser_r       (laser_r),
        .laser_deg     (laser_deg),
        .alien_present (alien_present)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fv = 0, n_pe = 0, n_se = 0;

    // Reference model: bits collected in a queue; a frame resolves after FW+1 accepted bits.
    bit            m_in_frame = 1'b0;
    logic          m_bits[$];
    bit            m_pending = 1'b0;
    bit            m_pend_good = 1'b0;
    logic [FW-1:0] m_pend_frame = '0;
    logic [FW-1:0] e_frame = '0;
    logic [7:0]    e_cnt = '0;
    bit            e_fv = 0, e_pe = 0, e_se = 0, e_busy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic v, input logic s, input logic d);
        logic p;
        e_fv = 0; e_pe = 0; e_se = 0;
        if (rst) begin
            m_in_frame = 0; m_bits.delete(); m_pending = 0; e_frame = '0; e_cnt = '0;
        end else begin
            if (m_pending) begin
                m_pending = 0;
                if (m_pend_good) begin
                    e_frame = m_pend_frame; e_cnt = e_cnt + 8'd1; e_fv = 1;
                end else begin
                    e_pe = 1;
                end
            end
            if (m_in_frame) begin
                if (v && s) begin
                    e_se = 1; m_bits.delete(); m_bits.push_back(d);
                end else if (v) begin
                    m_bits.push_back(d);
                    if (m_bits.size() == FW + 1) begin
                        p = 1'b0;
                        foreach (m_bits[i]) p = p ^ m_bits[i];
                        for (int i = 0; i < FW; i++) m_pend_frame[i] = m_bits[i];
                        m_pend_good = (p == 1'b0);
                        m_pending = 1; m_in_frame = 0;
                    end
                end
            end else if (v && s) begin
                m_in_frame = 1; m_bits.delete(); m_bits.push_back(d);
            end
        end
        e_busy = m_in_frame;
    endtask

    task automatic compare_all();
        check("frame_out", 64'(frame_out), 64'(e_frame));
        check("frame_cnt", 64'(frame_cnt), 64'(e_cnt));
        check("frame_valid", 64'(frame_valid), 64'(e_fv));
        check("parity_err", 64'(parity_err), 64'(e_pe));
        check("sync_err", 64'(sync_err), 64'(e_se));
        check("busy", 64'(busy), 64'(e_busy));
        check("laser_active", 64'(laser_active), 64'(e_frame[0]));
        check("laser_r", 64'(laser_r), 64'(e_frame[4:1]));
        check("laser_deg", 64'(laser_deg), 64'(e_frame[13:5]));
        check("alien_present", 64'(alien_present), 64'({e_frame[LW+AW], e_frame[LW]}));
        check("pulse_excl", 64'((32'(frame_valid) + 32'(parity_err) + 32'(sync_err)) > 1), 64'(0));
    endtask

    task automatic step(input logic v, input logic s, input logic d);
        ser_valid = v; ser_sof = s; ser_data = d;
        @(posedge clk);
        model_edge(v, s, d);
        #1;
        compare_all();
        if (frame_valid === 1'b1) n_fv++;
        if (parity_err === 1'b1) n_pe++;
        if (sync_err === 1'b1) n_se++;
    endtask

    task automatic send_frame(input logic [FW-1:0] payload, input bit flip, input int stall_pct);
        logic par, b;
        par = (^payload) ^ flip;
        for (int i = 0; i <= FW; i++) begin
            while (int'($urandom_range(99)) < stall_pct)
                step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            b = (i < FW) ? payload[i] : par;
            step(1'b1, i == 0, b);
        end
    endtask

    function automatic logic [AW-1:0] alien(input logic p, input logic [1:0] t, input logic [1:0] f,
                                            input logic [3:0] r, input logic [8:0] th);
        return {th, r, f, t, p};
    endfunction

    function automatic logic [LW-1:0] laser(input logic a, input logic [3:0] r, input logic [8:0] d);
        return {d, r, a};
    endfunction

    function automatic logic [FW-1:0] rand_payload();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[FW-1:0];
    endfunction

    typedef struct {
        logic [FW-1:0] payload;
        bit            flip;
        logic          exp_fv;
        logic          exp_pe;
        logic [7:0]    exp_cnt;
        logic          exp_active;
        logic [3:0]    exp_r;
        logic [8:0]    exp_deg;
        logic [1:0]    exp_present;
        logic [FW-1:0] exp_frame;
    } vec_t;

    vec_t          vecs[5];
    logic [FW-1:0] p0, p2, p4, pg;
    int            fv0, pe0, se0;

    initial begin
        p0 = {alien(0, 0, 0, 0, 0), alien(1, 2'd2, 2'd0, 4'd9, 9'd200), laser(1, 4'd3, 9'd135)};
        p2 = {alien(1, 2'd3, 2'd0, 4'd15, 9'd300), alien(1, 2'd1, 2'd3, 4'd4, 9'd7),
              laser(0, 4'd15, 9'd511)};
        p4 = {alien(1, 0, 0, 0, 0), alien(0, 0, 0, 0, 0), laser(1, 4'd7, 9'd0)};
        vecs[0] = '{payload: p0, flip: 0, exp_fv: 1, exp_pe: 0, exp_cnt: 1, exp_active: 1,
                    exp_r: 3, exp_deg: 135, exp_present: 2'b01, exp_frame: p0};
        vecs[1] = '{payload: p0, flip: 1, exp_fv: 0, exp_pe: 1, exp_cnt: 1, exp_active: 1,
                    exp_r: 3, exp_deg: 135, exp_present: 2'b01, exp_frame: p0};
        vecs[2] = '{payload: p2, flip: 0, exp_fv: 1, exp_pe: 0, exp_cnt: 2, exp_active: 0,
                    exp_r: 15, exp_deg: 511, exp_present: 2'b11, exp_frame: p2};
        vecs[3] = '{payload: '0, flip: 0, exp_fv: 1, exp_pe: 0, exp_cnt: 3, exp_active: 0,
                    exp_r: 0, exp_deg: 0, exp_present: 2'b00, exp_frame: '0};
        vecs[4] = '{payload: p4, flip: 1, exp_fv: 0, exp_pe: 1, exp_cnt: 3, exp_active: 0,
                    exp_r: 0, exp_deg: 0, exp_present: 2'b00, exp_frame: '0};

        // Reset state.
        rst = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0);
        check("reset_frame_out", 64'(frame_out), 64'(0));
        check("reset_frame_cnt", 64'(frame_cnt), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));

        // Table-driven frames, each observed one cycle after its parity beat.
        foreach (vecs[i]) begin
            send_frame(vecs[i].payload, vecs[i].flip, 0);
            check("tbl_valid_early", 64'(frame_valid), 64'(0));
            step(0, 0, 0);
            check("tbl_frame_valid", 64'(frame_valid), 64'(vecs[i].exp_fv));
            check("tbl_parity_err", 64'(parity_err), 64'(vecs[i].exp_pe));
            check("tbl_frame_cnt", 64'(frame_cnt), 64'(vecs[i].exp_cnt));
            check("tbl_laser_active", 64'(laser_active), 64'(vecs[i].exp_active));
            check("tbl_laser_r", 64'(laser_r), 64'(vecs[i].exp_r));
            check("tbl_laser_deg", 64'(laser_deg), 64'(vecs[i].exp_deg));
            check("tbl_alien_present", 64'(alien_present), 64'(vecs[i].exp_present));
            check("tbl_frame_out", 64'(frame_out), 64'(vecs[i].exp_frame));
        end

        // Early sof at bit 20, then a full good frame restarting on that sof.
        fv0 = n_fv; se0 = n_se;
        for (int i = 0; i < 20; i++) step(1, i == 0, 1'($urandom_range(1)));
        ser_valid = 1; ser_sof = 1; ser_data = p2[0];
        step(1, 1, p2[0]);
        check("sync_sof_pulse", 64'(sync_err), 64'(1));
        for (int i = 1; i < FW; i++) step(1, 0, p2[i]);
        step(1, 0, ^p2);
        step(0, 0, 0);
        check("sync_frame_valid", 64'(frame_valid), 64'(1));
        check("sync_frame_out", 64'(frame_out), 64'(p2));
        check("sync_frame_cnt", 64'(frame_cnt), 64'(4));
        check("sync_pulse_count", 64'(n_se - se0), 64'(1));

        // sof landing in the parity slot also aborts.
        se0 = n_se;
        for (int i = 0; i < FW; i++) step(1, i == 0, p0[i]);
        send_frame(p0, 0, 0);
        step(0, 0, 0);
        check("sync_parity_slot", 64'(n_se - se0), 64'(1));
        check("sync_parity_cnt", 64'(frame_cnt), 64'(5));

        // Heavy stalls must not change the assembled frame.
        send_frame(p0, 0, 50);
        step(0, 0, 0);
        check("stall_frame_out", 64'(frame_out), 64'(p0));
        check("stall_frame_cnt", 64'(frame_cnt), 64'(6));

        // Headless bits in IDLE, then reset mid-frame.
        fv0 = n_fv; pe0 = n_pe; se0 = n_se;
        for (int i = 0; i < 10; i++) step(1, 0, 1'($urandom_range(1)));
        for (int i = 0; i < 30; i++) step(1, i == 0, p2[i]);
        check("midrst_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        step(1, 0, 1);
        rst = 1'b0;
        check("midrst_frame_out", 64'(frame_out), 64'(0));
        check("midrst_frame_cnt", 64'(frame_cnt), 64'(0));
        check("midrst_no_pulses", 64'((n_fv - fv0) + (n_pe - pe0) + (n_se - se0)), 64'(0));
        for (int i = 30; i < FW; i++) step(1, 0, p2[i]);
        step(1, 0, 1);
        send_frame(p2, 0, 0);
        step(0, 0, 0);
        check("midrst_next_cnt", 64'(frame_cnt), 64'(1));
        check("midrst_next_frame", 64'(frame_out), 64'(p2));

        // 256 random frames back to back (each sof in the commit cycle): counter wraps.
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        fv0 = n_fv;
        for (int f = 0; f < 256; f++) begin
            pg = rand_payload();
            send_frame(pg, 0, 0);
        end
        step(0, 0, 0);
        check("wrap_frame_cnt", 64'(frame_cnt), 64'(0));
        check("wrap_frames_seen", 64'(n_fv - fv0), 64'(256));
        check("wrap_last_frame", 64'(frame_out), 64'(pg));

        // Random frames with random stalls and corrupted parity.
        for (int f = 0; f < 20; f++) begin
            send_frame(rand_payload(), 1'($urandom_range(3) == 0), int'($urandom_range(60)));
            if ($urandom_range(1) == 1) step(0, 0, 0);
        end

        // Unstructured random beats with sparse sof.
        for (int c = 0; c < 3000; c++)
            step(1'($urandom_range(99) < 80), 1'($urandom_range(99) < 2), 1'($urandom_range(1)));
        step(0, 0, 0);
        step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
